// File: rtl/result_pack_fifo.sv
// result_pack_fifo: packs FP16 results into LANES-wide lines, buffers them in BRAM behind a FWFT output register; ports: i_clk/i_reset_n/i_clear, write (i_wr_data,i_wr_en,o_full), flush (i_flush,o_flush_done), read (o_rd_data,o_rd_valid,i_rd_ready), status (o_line_count,o_partial_count,o_overflow)
module result_pack_fifo #(
  parameter int DEPTH = 64,
  parameter int LANES = 8,
  parameter int FULL_MARGIN = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clear,
  input  logic [15:0]             i_wr_data,
  input  logic                    i_wr_en,
  output logic                    o_full,
  input  logic                    i_flush,
  output logic                    o_flush_done,
  output logic [16*LANES-1:0]     o_rd_data,
  output logic                    o_rd_valid,
  input  logic                    i_rd_ready,
  output logic [$clog2(DEPTH):0]  o_line_count,
  output logic [$clog2(LANES):0]  o_partial_count,
  output logic                    o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LANES);
  localparam int FW = $clog2(DEPTH*LANES) + 2;
  logic [LANES-1:0][15:0] lanes, line, q;
  logic [LANES-1:0][15:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] mem_count;
  logic [FW-1:0] free;
  logic qv, wr_ok, commit, pop, load, issue;
  always_comb begin
    free = (FW'(DEPTH) - FW'(o_line_count)) * FW'(LANES) - FW'(o_partial_count);
    wr_ok = i_wr_en && free != '0;
    commit = (wr_ok && o_partial_count == (LW+1)'(LANES-1)) || (i_flush && o_partial_count != '0);
    pop = o_rd_valid && i_rd_ready;
    load = qv && (!o_rd_valid || pop);
    issue = mem_count != '0 && (!qv || load);
    line = lanes;
    if (wr_ok) line[o_partial_count[LW-1:0]] = i_wr_data;
  end
  assign o_full = free <= FW'(FULL_MARGIN);
  always_ff @(posedge i_clk) begin
    if (commit) mem[wptr] <= line;
    if (issue) q <= mem[rptr];
  end
  always_ff @(posedge i_clk)
    if (!i_reset_n || i_clear) begin
      lanes <= '0;
      o_partial_count <= '0;
      wptr <= '0;
      rptr <= '0;
      mem_count <= '0;
      qv <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data <= '0;
      o_line_count <= '0;
      o_overflow <= 1'b0;
      o_flush_done <= 1'b0;
    end else begin
      o_flush_done <= i_flush;
      if (i_wr_en && !wr_ok) o_overflow <= 1'b1;
      lanes <= commit ? '0 : line;
      if (commit) o_partial_count <= '0;
      else if (wr_ok) o_partial_count <= o_partial_count + (LW+1)'(1);
      if (commit) wptr <= wptr + AW'(1);
      if (issue) rptr <= rptr + AW'(1);
      mem_count <= mem_count + (AW+1)'(commit) - (AW+1)'(issue);
      qv <= issue || (qv && !load);
      if (load) o_rd_data <= q;
      o_rd_valid <= load || (o_rd_valid && !pop);
      o_line_count <= o_line_count + (AW+1)'(commit) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_result_pack_fifo.sv
// tb_result_pack_fifo: directed self-checking bench for result_pack_fifo
module tb_result_pack_fifo;
  logic clk = 1'b0;
  logic rst_n, clear, wr_en, full, flush, flush_done, valid, ready, overflow;
  logic [15:0] wr_data;
  logic [127:0] data;
  logic [6:0] lc;
  logic [3:0] pc;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  result_pack_fifo dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .o_full(full), .i_flush(flush), .o_flush_done(flush_done), .o_rd_data(data),
    .o_rd_valid(valid), .i_rd_ready(ready), .o_line_count(lc), .o_partial_count(pc),
    .o_overflow(overflow)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  function automatic logic [127:0] mk(input int base, input int n);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[16*k +: 16] = 16'(base + k);
    return r;
  endfunction
  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; ready = 1'b0;
    step();
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (lc !== 0 || pc !== 0) begin errors++; $display("FAIL reset_counts: got lc=%0d pc=%0d want 0 0", lc, pc); end
    checks++; if (overflow !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b fd=%b want 0 0", overflow, flush_done); end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_single_line();
    ready = 1'b1;
    for (int i = 1; i <= 8; i++) wr(16'(i));
    checks++; if (pc !== 0 || lc !== 1 || valid !== 1'b0) begin errors++; $display("FAIL line_commit: got pc=%0d lc=%0d v=%b want 0 1 0", pc, lc, valid); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL line_latency1: got v=%b want 0", valid); end
    step();
    checks++; if (valid !== 1'b1 || data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin errors++; $display("FAIL line_data: got v=%b %h want 1 %h", valid, data, 128'h0008_0007_0006_0005_0004_0003_0002_0001); end
    step();
    checks++; if (lc !== 0 || valid !== 1'b0) begin errors++; $display("FAIL line_pop: got lc=%0d v=%b want 0 0", lc, valid); end
  endtask
  task automatic test_flush();
    ready = 1'b1;
    wr(16'h0A01); wr(16'h0A02); wr(16'h0A03);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (flush_done !== 1'b1 || pc !== 0 || lc !== 1) begin errors++; $display("FAIL flush_commit: got fd=%b pc=%0d lc=%0d want 1 0 1", flush_done, pc, lc); end
    step();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_pulse: got fd=%b want 0", flush_done); end
    step();
    checks++; if (valid !== 1'b1 || data !== mk(16'h0A01, 3)) begin errors++; $display("FAIL flush_data: got v=%b %h want 1 %h", valid, data, mk(16'h0A01, 3)); end
    step();
    checks++; if (lc !== 0) begin errors++; $display("FAIL flush_pop: got lc=%0d want 0", lc); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (flush_done !== 1'b1 || lc !== 0) begin errors++; $display("FAIL flush_empty: got fd=%b lc=%0d want 1 0", flush_done, lc); end
    step();
    checks++; if (flush_done !== 1'b0 || valid !== 1'b0 || lc !== 0) begin errors++; $display("FAIL flush_empty_after: got fd=%b v=%b lc=%0d want 0 0 0", flush_done, valid, lc); end
  endtask
  task automatic test_fill_overflow();
    int got;
    ready = 1'b0;
    for (int i = 0; i < 513; i++) begin
      wr(16'(i));
      if (i + 1 == 507) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0 at 507", full); end end
      if (i + 1 == 508) begin checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_rise: got %b want 1 at 508", full); end end
      if (i + 1 == 512) begin checks++; if (overflow !== 1'b0 || lc !== 64) begin errors++; $display("FAIL fill_512: got ovf=%b lc=%0d want 0 64", overflow, lc); end end
      if (i + 1 == 513) begin checks++; if (overflow !== 1'b1 || lc !== 64 || pc !== 0) begin errors++; $display("FAIL overflow: got ovf=%b lc=%0d pc=%0d want 1 64 0", overflow, lc, pc); end end
    end
    ready = 1'b1;
    got = 0;
    for (int c = 0; c < 300 && got < 64; c++) begin
      if (valid) begin
        checks++; if (data !== mk(8 * got, 8)) begin errors++; $display("FAIL drain_line%0d: got %h want %h", got, data, mk(8 * got, 8)); end
        got++;
      end
      step();
    end
    ready = 1'b0;
    checks++; if (got !== 64 || lc !== 0) begin errors++; $display("FAIL drain_count: got lines=%0d lc=%0d want 64 0", got, lc); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", overflow); end
  endtask
  task automatic test_flush_coincide();
    ready = 1'b1;
    for (int i = 0; i < 7; i++) wr(16'(16'h0B01 + i));
    flush = 1'b1;
    wr(16'h0B08);
    flush = 1'b0;
    checks++; if (flush_done !== 1'b1 || lc !== 1 || pc !== 0) begin errors++; $display("FAIL coincide_commit: got fd=%b lc=%0d pc=%0d want 1 1 0", flush_done, lc, pc); end
    step();
    step();
    checks++; if (valid !== 1'b1 || data !== mk(16'h0B01, 8)) begin errors++; $display("FAIL coincide_data: got v=%b %h want 1 %h", valid, data, mk(16'h0B01, 8)); end
    step();
    step();
    step();
    checks++; if (valid !== 1'b0 || lc !== 0) begin errors++; $display("FAIL coincide_extra: got v=%b lc=%0d want 0 0", valid, lc); end
  endtask
  task automatic test_stream();
    int wi, n, gap, maxgap;
    logic pv, pr;
    logic [127:0] pd;
    wi = 0; n = 0; gap = 0; maxgap = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    for (int c = 0; c < 20000 && n < 128; c++) begin
      step();
      if (pv && !pr) begin
        checks++; if (valid !== 1'b1 || data !== pd) begin errors++; $display("FAIL stall_hold: got v=%b %h want 1 %h", valid, data, pd); end
      end
      ready = 1'($urandom_range(0, 1));
      gap = (ready && !valid && lc >= 2) ? gap + 1 : 0;
      if (gap > maxgap) maxgap = gap;
      wr_en = wi < 1024 && !full;
      wr_data = 16'(wi);
      if (wr_en) wi++;
      if (valid && ready) begin
        checks++; if (data !== mk(8 * n, 8)) begin errors++; $display("FAIL stream_line%0d: got %h want %h", n, data, mk(8 * n, 8)); end
        n++;
      end
      pv = valid; pr = ready; pd = data;
    end
    step();
    wr_en = 1'b0;
    ready = 1'b0;
    checks++; if (n !== 128 || lc !== 0 || overflow !== 1'b0) begin errors++; $display("FAIL stream_end: got lines=%0d lc=%0d ovf=%b want 128 0 0", n, lc, overflow); end
    checks++; if (maxgap > 1) begin errors++; $display("FAIL stream_gap: got %0d want <=1", maxgap); end
  endtask
  task automatic test_clear(input bit use_reset);
    ready = 1'b0;
    for (int i = 0; i < 83; i++) wr(16'(16'h0100 + i));
    checks++; if (lc !== 10 || pc !== 3) begin errors++; $display("FAIL preclear_counts: got lc=%0d pc=%0d want 10 3", lc, pc); end
    if (use_reset) rst_n = 1'b0; else clear = 1'b1;
    step();
    rst_n = 1'b1;
    clear = 1'b0;
    checks++; if (valid !== 1'b0 || lc !== 0 || pc !== 0 || overflow !== 1'b0 || data !== '0) begin errors++; $display("FAIL clear_state(%0d): got v=%b lc=%0d pc=%0d ovf=%b d=%h want 0 0 0 0 0", use_reset, valid, lc, pc, overflow, data); end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) wr(16'(16'h0C01 + i));
    step();
    step();
    checks++; if (valid !== 1'b1 || data !== mk(16'h0C01, 8)) begin errors++; $display("FAIL clear_fresh(%0d): got v=%b %h want 1 %h", use_reset, valid, data, mk(16'h0C01, 8)); end
    step();
    checks++; if (lc !== 0 || valid !== 1'b0) begin errors++; $display("FAIL clear_pop(%0d): got lc=%0d v=%b want 0 0", use_reset, lc, valid); end
  endtask
  initial begin
    test_reset();
    test_single_line();
    test_flush();
    test_fill_overflow();
    test_flush_coincide();
    test_stream();
    test_clear(1'b0);
    test_clear(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
